// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cIn;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cOut;

  modport master (
    output start, a, b, cIn,
    input  busy, done, s, cOut
  );

  modport slave (
    input  start, a, b, cIn,
    output busy, done, s, cOut
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: one full-adder slice plus a carry flop, LSB first.
// The sum {cOut, s} equals a + b + cIn; s and cOut hold between completions.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic           clk,
  input  logic           rstN,
  serial_adder_if.slave  bus
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] r_sh_q, r_sh_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;

  logic             sum_bit;
  logic             carry_nx;

  // Full-adder slice on the current LSBs and next-state/output computation
  always_comb begin
    sum_bit  = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    carry_nx = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);

    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    r_sh_d  = r_sh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    cout_d  = cout_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          carry_d = bus.cIn;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        r_sh_d  = {sum_bit, r_sh_q[WIDTH-1:1]};
        carry_d = carry_nx;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          // Result registers take the completed word on the edge entering DONE
          s_d     = {sum_bit, r_sh_q[WIDTH-1:1]};
          cout_d  = carry_nx;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      r_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      r_sh_q  <= r_sh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.s    = s_q;
  assign bus.cOut = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed plus randomized bench for serial_adder (WIDTH=8).
module tb_serial_adder;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [W-1:0] prev_s = '0;
  logic         prev_c = 1'b0;
  logic [W-1:0] exp_s;
  logic         exp_c;

  task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain unsigned (W+1)-bit addition
  task automatic expect_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci);
    int unsigned sum;
    sum   = int'(av) + int'(bv) + int'(ci);
    exp_s = sum[W-1:0];
    exp_c = sum[W];
  endtask

  // Called just after the accepting edge E0; follows the run to E0+W+1
  task automatic run_op(input logic keep, input logic noise);
    chk("busy_e0", bus.busy, 1);
    chk("done_e0", bus.done, 0);
    for (int i = 1; i < W; i++) begin
      if (noise) begin
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.cIn   = 1'($urandom);
        bus.start = 1'($urandom);
        if (i == 2) begin
          bus.start = 1'b1;
          bus.a     = 8'h01;
          bus.b     = 8'h01;
        end
      end
      tick();
      chk("busy_run", bus.busy, 1);
      chk("done_run", bus.done, 0);
      chk("s_hold_run", bus.s, prev_s);
      chk("c_hold_run", bus.cOut, prev_c);
    end
    tick();
    chk("done_hi", bus.done, 1);
    chk("busy_done", bus.busy, 0);
    chk("s_result", bus.s, exp_s);
    chk("c_result", bus.cOut, exp_c);
    if (!keep) bus.start = 1'b0;
    prev_s = exp_s;
    prev_c = exp_c;
    tick();
    chk("done_lo", bus.done, 0);
    chk("busy_idle", bus.busy, 0);
    chk("s_hold_after", bus.s, prev_s);
    chk("c_hold_after", bus.cOut, prev_c);
  endtask

  task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                        input logic keep, input logic noise);
    expect_op(av, bv, ci);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    bus.cIn   = ci;
    tick();
    bus.start = keep;
    run_op(keep, noise);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cIn   = 1'b0;

    // Reset state
    #12;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_s", bus.s, 0);
    chk("rst_c", bus.cOut, 0);
    tick();
    rstN = 1'b1;
    tick();
    tick();
    chk("idle_busy", bus.busy, 0);

    // Directed operations
    launch(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    launch(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    launch(8'h5A, 8'hA5, 1'b1, 1'b0, 1'b0);
    launch(8'h5A, 8'hA5, 1'b0, 1'b0, 1'b0);
    launch(8'h3C, 8'h0F, 1'b0, 1'b0, 1'b1);
    tick();
    chk("no_relaunch", bus.busy, 0);

    // Reset mid-operation
    bus.start = 1'b1;
    bus.a     = 8'hF0;
    bus.b     = 8'h0F;
    bus.cIn   = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    @(posedge clk);
    rstN = 1'b0;
    #1;
    chk("mrst_busy", bus.busy, 0);
    chk("mrst_done", bus.done, 0);
    chk("mrst_s", bus.s, 0);
    chk("mrst_c", bus.cOut, 0);
    tick();
    tick();
    chk("mrst_no_done", bus.done, 0);
    rstN = 1'b1;
    prev_s = '0;
    prev_c = 1'b0;
    tick();
    launch(8'h12, 8'h34, 1'b0, 1'b0, 1'b0);

    // start held high across two back-to-back operations
    launch(8'h80, 8'h80, 1'b1, 1'b1, 1'b0);
    bus.a   = 8'h01;
    bus.b   = 8'hFE;
    bus.cIn = 1'b1;
    expect_op(8'h01, 8'hFE, 1'b1);
    tick();
    bus.start = 1'b0;
    run_op(1'b0, 1'b0);

    // Randomized operations against the arithmetic reference
    for (int n = 0; n < 24; n++) begin
      launch(W'($urandom), W'($urandom), 1'($urandom), 1'b0, 1'($urandom));
      if (($urandom & 1) != 0) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
